// File: rtl/rgmii_rx_deframer.sv
// rgmii_rx_deframer
// Receive-side RGMII deframer. Takes nibbles and RX_CTL already captured on
// both edges by an external DDR input register (125 MHz receive domain), finds
// preamble/SFD, rebuilds payload bytes, checks the Ethernet CRC-32 and frame
// length, and presents a byte stream with frame-boundary/status strobes.
//
// Ports:
//   clock        125 MHz receive clock, rising-edge domain
//   reset        synchronous, active-high reset
//   rx_nib_h     nibble captured on rising edge  (byte bits 3:0)
//   rx_nib_l     nibble captured on falling edge (byte bits 7:4)
//   rx_ctl_h     RX_CTL at rising edge  (= RX_DV)
//   rx_ctl_l     RX_CTL at falling edge (= RX_DV xor RX_ER)
//   data         received byte, FCS bytes included
//   data_valid   data holds a post-SFD frame byte this cycle
//   frame_start  pulse with the first post-SFD byte
//   frame_end    pulse after the last byte; status outputs valid with it
//   crc_ok       CRC residue correct; held until next frame_start
//   runt         byte count < MIN_FRAME; held until next frame_start
//   rx_error     RX_ER, bad length; held until next frame_start
//   active       high whenever the FSM is not idle
//
// The pins are registered exactly once: every output is a flop whose next
// value is computed from the raw pins and the current state, so outputs trail
// the pins by one clock.

module rgmii_rx_deframer #(
  parameter logic [3:0]  PREAMB_MIN = 4'd2,
  parameter logic [10:0] MIN_FRAME  = 11'd64,
  parameter logic [10:0] MAX_FRAME  = 11'd1522
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] rx_nib_h,
  input  logic [3:0] rx_nib_l,
  input  logic       rx_ctl_h,
  input  logic       rx_ctl_l,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_start,
  output logic       frame_end,
  output logic       crc_ok,
  output logic       runt,
  output logic       rx_error,
  output logic       active
);

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  // Register value left after running a good frame's own FCS through the CRC.
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_DROP     = 2'd3
  } state_t;

  // One byte of reflected CRC-32, LSB first, fully combinational.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                             input logic [7:0]  d);
    logic [31:0] c;
    c = crc_in ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = (c >> 1) ^ CRC_POLY;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  logic       dv_s;
  logic       er_s;
  logic [7:0] byte_s;

  state_t      state_r,    state_s;
  logic [3:0]  pre_cnt_r,  pre_cnt_s;
  logic [10:0] byte_cnt_r, byte_cnt_s;
  logic [31:0] crc_r,      crc_s;

  logic [7:0] data_r,        data_s;
  logic       data_valid_r,  data_valid_s;
  logic       frame_start_r, frame_start_s;
  logic       frame_end_r,   frame_end_s;
  logic       crc_ok_r,      crc_ok_s;
  logic       runt_r,        runt_s;
  logic       rx_error_r,    rx_error_s;
  logic       active_r,      active_s;

  assign dv_s   = rx_ctl_h;
  assign er_s   = rx_ctl_h ^ rx_ctl_l;
  assign byte_s = {rx_nib_l, rx_nib_h};

  // Next-state, counter, CRC and output computation.
  always_comb begin
    state_s       = state_r;
    pre_cnt_s     = pre_cnt_r;
    byte_cnt_s    = byte_cnt_r;
    crc_s         = crc_r;
    data_s        = data_r;
    data_valid_s  = 1'b0;
    frame_start_s = 1'b0;
    frame_end_s   = 1'b0;
    crc_ok_s      = crc_ok_r;
    runt_s        = runt_r;
    rx_error_s    = rx_error_r;

    case (state_r)
      ST_IDLE: begin
        // dv=0 with er=1 is carrier extend / in-band status: ignored here.
        if (dv_s && !er_s && (byte_s == 8'h55)) begin
          pre_cnt_s = 4'd1;
          state_s   = ST_PREAMBLE;
        end else if (dv_s) begin
          state_s = ST_DROP;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_PREAMBLE: begin
        if (!dv_s) begin
          state_s = ST_IDLE;
        end else if (er_s) begin
          state_s = ST_DROP;
        end else if (byte_s == 8'h55) begin
          if (pre_cnt_r != 4'd15) begin
            pre_cnt_s = pre_cnt_r + 4'd1;
          end else begin
            pre_cnt_s = pre_cnt_r;
          end
        end else if ((byte_s == 8'hD5) && (pre_cnt_r >= PREAMB_MIN)) begin
          state_s    = ST_PAYLOAD;
          crc_s      = CRC_INIT;
          byte_cnt_s = 11'd0;
        end else begin
          state_s = ST_DROP;
        end
      end

      ST_PAYLOAD: begin
        if (!dv_s) begin
          // Normal end of frame. A zero-length frame lands here too and
          // reports runt with crc_ok low since crc is still the seed.
          frame_end_s = 1'b1;
          crc_ok_s    = (crc_r == CRC_RESIDUE);
          runt_s      = (byte_cnt_r < MIN_FRAME);
          state_s     = ST_IDLE;
        end else if (er_s) begin
          rx_error_s  = 1'b1;
          frame_end_s = 1'b1;
          state_s     = ST_DROP;
        end else if (byte_cnt_r >= MAX_FRAME) begin
          // Accepting this byte would exceed MAX_FRAME.
          rx_error_s  = 1'b1;
          frame_end_s = 1'b1;
          state_s     = ST_DROP;
        end else begin
          data_s       = byte_s;
          data_valid_s = 1'b1;
          crc_s        = crc32_byte(crc_r, byte_s);
          if (byte_cnt_r != 11'h7FF) begin
            byte_cnt_s = byte_cnt_r + 11'd1;
          end else begin
            byte_cnt_s = byte_cnt_r;
          end
          if (byte_cnt_r == 11'd0) begin
            frame_start_s = 1'b1;
            crc_ok_s      = 1'b0;
            runt_s        = 1'b0;
            rx_error_s    = 1'b0;
          end else begin
            frame_start_s = 1'b0;
          end
        end
      end

      ST_DROP: begin
        if (!dv_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DROP;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    active_s = (state_s != ST_IDLE);
  end

  // State, counters, CRC and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      pre_cnt_r     <= 4'd0;
      byte_cnt_r    <= 11'd0;
      crc_r         <= CRC_INIT;
      data_r        <= 8'h00;
      data_valid_r  <= 1'b0;
      frame_start_r <= 1'b0;
      frame_end_r   <= 1'b0;
      crc_ok_r      <= 1'b0;
      runt_r        <= 1'b0;
      rx_error_r    <= 1'b0;
      active_r      <= 1'b0;
    end else begin
      state_r       <= state_s;
      pre_cnt_r     <= pre_cnt_s;
      byte_cnt_r    <= byte_cnt_s;
      crc_r         <= crc_s;
      data_r        <= data_s;
      data_valid_r  <= data_valid_s;
      frame_start_r <= frame_start_s;
      frame_end_r   <= frame_end_s;
      crc_ok_r      <= crc_ok_s;
      runt_r        <= runt_s;
      rx_error_r    <= rx_error_s;
      active_r      <= active_s;
    end
  end

  assign data        = data_r;
  assign data_valid  = data_valid_r;
  assign frame_start = frame_start_r;
  assign frame_end   = frame_end_r;
  assign crc_ok      = crc_ok_r;
  assign runt        = runt_r;
  assign rx_error    = rx_error_r;
  assign active      = active_r;

endmodule
